// File: rtl/ps2_tx_pkg.sv
// Shared types and 7 MHz default timing for the PS/2 host-to-device transmitter.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    PARITY   = 3'd4,
    STOP     = 3'd5,
    ACK      = 3'd6,
    WAITIDLE = 3'd7
  } state_t;

  localparam int DEF_INHIBIT_CYCLES = 700;     // 100 us at 7 MHz
  localparam int DEF_TIMEOUT_CYCLES = 105000;  // 15 ms at 7 MHz
  localparam int DEF_FILTER_LEN     = 4;

  localparam int INH_W = 10;
  localparam int TO_W  = 17;
  localparam int IDX_W = 3;

  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command handshake between the keyboard controller and the PS/2 transmitter.
interface ps2_tx_if;
  logic       send;
  logic [7:0] command;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output send, output command, input busy, input done, input error);
  modport slave  (input send, input command, output busy, output done, output error);
endinterface

// File: rtl/ps2_line_sync.sv
// Pad synchronizers for the PS/2 lines plus a run-length filter on the clock.
module ps2_line_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clockPs2,
  input  logic reset,
  input  logic clkIn,
  input  logic datIn,
  output logic clkF,
  output logic datS,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic          clkS1;
  logic          clkS;
  logic          datS1;
  logic [CW-1:0] filtCnt;

  // filtCnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clockPs2) begin
    if (reset) begin
      clkS1   <= 1'b1;
      clkS    <= 1'b1;
      datS1   <= 1'b1;
      datS    <= 1'b1;
      clkF    <= 1'b1;
      filtCnt <= '0;
      fall    <= 1'b0;
    end else begin
      clkS1 <= clkIn;
      clkS  <= clkS1;
      datS1 <= datIn;
      datS  <= datS1;
      fall  <= 1'b0;
      if (clkS == clkF) begin
        filtCnt <= '0;
      end else if (filtCnt == CW'(FILTER_LEN - 1)) begin
        clkF    <= clkS;
        filtCnt <= '0;
        fall    <= ~clkS;
      end else begin
        filtCnt <= filtCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks out one command
// byte on device-generated clock falls and checks the device ACK.
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic        clockPs2,
  input  logic        reset,
  ps2_tx_if.slave     host,
  input  logic        ps2ClkIn,
  input  logic        ps2DatIn,
  output logic        ps2ClkOe,
  output logic        ps2DatOe
);

  state_t             state;
  state_t             nextState;
  logic               clkF;
  logic               datS;
  logic               fall;
  logic [INH_W-1:0]   inhCnt;
  logic [TO_W-1:0]    toCnt;
  logic [8:0]         shift;
  logic [IDX_W-1:0]   bitIdx;
  logic               datOeR;
  logic               ackBit;
  logic               counting;
  logic               timeout;
  logic               doneSet;
  logic               errSet;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clockPs2 (clockPs2),
    .reset    (reset),
    .clkIn    (ps2ClkIn),
    .datIn    (ps2DatIn),
    .clkF     (clkF),
    .datS     (datS),
    .fall     (fall)
  );

  always_ff @(posedge clockPs2) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    counting = (state == START) || (state == DATA) || (state == PARITY) ||
               (state == STOP) || (state == ACK) || (state == WAITIDLE);
    timeout  = counting && (toCnt == '0);
  end

  always_comb begin
    nextState = state;
    doneSet   = 1'b0;
    errSet    = 1'b0;
    case (state)
      IDLE:     if (host.send) nextState = INHIBIT;
      INHIBIT:  if (inhCnt == '0) nextState = START;
      START:    if (fall) nextState = DATA;
      DATA:     if (fall && bitIdx == '0) nextState = PARITY;
      PARITY:   if (fall) nextState = STOP;
      STOP:     if (fall) nextState = ACK;
      ACK: begin
        if (ackBit) begin
          nextState = IDLE;
          errSet    = 1'b1;
        end else begin
          nextState = WAITIDLE;
        end
      end
      WAITIDLE: begin
        if (clkF && datS) begin
          nextState = IDLE;
          doneSet   = 1'b1;
        end
      end
      default:  nextState = IDLE;
    endcase
    // timeout outranks any same-cycle fall or ACK decision
    if (timeout) begin
      nextState = IDLE;
      doneSet   = 1'b0;
      errSet    = 1'b1;
    end
  end

  always_comb begin
    ps2ClkOe   = (state == INHIBIT);
    ps2DatOe   = datOeR || ((state == INHIBIT) && (inhCnt == '0));
    host.busy  = (state != IDLE);
  end

  // bit index wraps 7 -> 0, so index 0 while in DATA means parity is next
  always_ff @(posedge clockPs2) begin
    if (reset) begin
      inhCnt     <= '0;
      toCnt      <= '0;
      shift      <= '0;
      bitIdx     <= '0;
      datOeR     <= 1'b0;
      ackBit     <= 1'b0;
      host.done  <= 1'b0;
      host.error <= 1'b0;
    end else begin
      host.done  <= doneSet;
      host.error <= errSet;
      case (state)
        IDLE: begin
          if (host.send) begin
            shift  <= {oddParity(host.command), host.command};
            inhCnt <= INH_W'(INHIBIT_CYCLES - 1);
            bitIdx <= '0;
            datOeR <= 1'b0;
          end
        end
        INHIBIT: begin
          if (inhCnt != '0) begin
            inhCnt <= inhCnt - 1'b1;
          end else begin
            datOeR <= 1'b1;
            toCnt  <= TO_W'(TIMEOUT_CYCLES - 1);
          end
        end
        START, DATA: begin
          if (fall) begin
            datOeR <= ~shift[0];
            shift  <= {1'b0, shift[8:1]};
            bitIdx <= bitIdx + 1'b1;
          end
        end
        PARITY:  if (fall) datOeR <= 1'b0;
        STOP:    if (fall) ackBit <= datS;
        default: ;
      endcase
      if (counting && toCnt != '0) toCnt <= toCnt - 1'b1;
      if (nextState == IDLE) datOeR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a behavioural PS/2 device clocks frames
// and the sampled line is compared against a frame built from the command.
module tb_ps2_tx;

  localparam int INH  = 20;
  localparam int TMO  = 1500;
  localparam int FLT  = 4;
  localparam int HALF = 15;

  logic clockPs2 = 1'b0;
  logic reset    = 1'b1;
  logic devClk   = 1'b1;
  logic devDat   = 1'b1;
  logic ps2ClkOe;
  logic ps2DatOe;
  wire  ps2ClkIn = devClk & ~ps2ClkOe;
  wire  ps2DatIn = devDat & ~ps2DatOe;

  ps2_tx_if hostIf();

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clockPs2 (clockPs2),
    .reset    (reset),
    .host     (hostIf),
    .ps2ClkIn (ps2ClkIn),
    .ps2DatIn (ps2DatIn),
    .ps2ClkOe (ps2ClkOe),
    .ps2DatOe (ps2DatOe)
  );

  always #5 clockPs2 = ~clockPs2;

  int npass = 0;
  int ntotal = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int bothCnt = 0;
  int cyc = 0;

  always @(posedge clockPs2) begin
    #1;
    cyc++;
    if (hostIf.done === 1'b1) doneCnt++;
    if (hostIf.error === 1'b1) errCnt++;
    if (hostIf.done === 1'b1 && hostIf.error === 1'b1) bothCnt++;
  end

  // start bit, data LSB first, odd parity, stop bit
  function automatic logic [10:0] expected_frame(input logic [7:0] cmd);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = cmd[i];
    f[9]  = ($countones(cmd) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic do_send(input logic [7:0] cmd);
    hostIf.command = cmd;
    hostIf.send    = 1'b1;
    @(negedge clockPs2);
    hostIf.send    = 1'b0;
  endtask

  task automatic device_frame(input bit ackLow, input int stopAfter, input bit glitch,
                              input bit resend, input logic [7:0] resendCmd,
                              output logic [10:0] seen, output int inhCycles,
                              output int datInInh, output bit released);
    seen = '0;
    inhCycles = 0;
    datInInh = 0;
    for (int i = 0; i < 20 && ps2ClkOe !== 1'b1; i++) @(negedge clockPs2);
    while (ps2ClkOe === 1'b1 && inhCycles < 4 * INH) begin
      inhCycles++;
      if (ps2DatOe === 1'b1) datInInh++;
      @(negedge clockPs2);
    end
    released = (ps2ClkOe === 1'b0) && (inhCycles > 0);
    if (!released) return;
    repeat (10) @(negedge clockPs2);
    seen[0] = ps2DatIn;
    for (int k = 1; k <= 11; k++) begin
      if (k > stopAfter) break;
      if (k == 11 && ackLow) devDat = 1'b0;
      devClk = 1'b0;
      for (int j = 0; j < HALF; j++) begin
        if (resend && k == 3 && j == 2) begin
          hostIf.command = resendCmd;
          hostIf.send    = 1'b1;
        end else begin
          hostIf.send    = 1'b0;
        end
        @(negedge clockPs2);
      end
      if (k <= 10) seen[k] = ps2DatIn;
      devClk = 1'b1;
      if (k == 11) devDat = 1'b1;
      for (int j = 0; j < HALF; j++) begin
        devClk = (glitch && k == 4 && j == 5) ? 1'b0 : 1'b1;
        @(negedge clockPs2);
      end
      devClk = 1'b1;
    end
  endtask

  task automatic wait_end(input int d0, input int e0);
    for (int i = 0; i < 300 && doneCnt == d0 && errCnt == e0; i++) @(negedge clockPs2);
    repeat (3) @(negedge clockPs2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hostIf.send = 1'b0;
    hostIf.command = 8'h00;
    repeat (3) @(negedge clockPs2);
    ntotal++; if (ps2ClkOe !== 1'b0) $display("FAIL reset_clkoe got %b want 0", ps2ClkOe); else npass++;
    ntotal++; if (ps2DatOe !== 1'b0) $display("FAIL reset_datoe got %b want 0", ps2DatOe); else npass++;
    ntotal++; if (hostIf.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", hostIf.busy); else npass++;
    ntotal++; if (hostIf.done !== 1'b0) $display("FAIL reset_done got %b want 0", hostIf.done); else npass++;
    ntotal++; if (hostIf.error !== 1'b0) $display("FAIL reset_error got %b want 0", hostIf.error); else npass++;
    reset = 1'b0;
    repeat (8) @(negedge clockPs2);
  endtask

  task automatic test_frame(input logic [7:0] cmd, input bit glitch, input bit resend, input string tag);
    logic [10:0] seen;
    logic [10:0] exp;
    int inh, dinh, d0, e0;
    bit rel;
    exp = expected_frame(cmd);
    d0 = doneCnt; e0 = errCnt;
    do_send(cmd);
    ntotal++; if (hostIf.busy !== 1'b1) $display("FAIL %s busy_after_send got %b want 1", tag, hostIf.busy); else npass++;
    device_frame(1'b1, 11, glitch, resend, ~cmd, seen, inh, dinh, rel);
    wait_end(d0, e0);
    ntotal++; if (rel !== 1'b1) $display("FAIL %s clock_release got %b want 1", tag, rel); else npass++;
    ntotal++; if (inh !== INH) $display("FAIL %s inhibit_len got %0d want %0d", tag, inh, INH); else npass++;
    ntotal++; if (dinh !== 1) $display("FAIL %s datoe_in_inhibit got %0d want 1", tag, dinh); else npass++;
    ntotal++; if (seen !== exp) $display("FAIL %s frame cmd=%h got %b want %b", tag, cmd, seen, exp); else npass++;
    ntotal++; if (doneCnt - d0 !== 1) $display("FAIL %s done_pulses got %0d want 1", tag, doneCnt - d0); else npass++;
    ntotal++; if (errCnt - e0 !== 0) $display("FAIL %s error_pulses got %0d want 0", tag, errCnt - e0); else npass++;
    ntotal++; if (hostIf.busy !== 1'b0) $display("FAIL %s busy_end got %b want 0", tag, hostIf.busy); else npass++;
    repeat (5) @(negedge clockPs2);
  endtask

  task automatic test_parity();
    logic [10:0] seen;
    int inh, dinh, d0, e0;
    bit rel;
    logic [7:0] cmds [2];
    logic       pexp [2];
    cmds[0] = 8'h01; pexp[0] = 1'b0;
    cmds[1] = 8'h00; pexp[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d0 = doneCnt; e0 = errCnt;
      do_send(cmds[i]);
      device_frame(1'b1, 11, 1'b0, 1'b0, 8'h00, seen, inh, dinh, rel);
      wait_end(d0, e0);
      ntotal++; if (seen[9] !== pexp[i]) $display("FAIL parity cmd=%h got %b want %b", cmds[i], seen[9], pexp[i]); else npass++;
      ntotal++; if (doneCnt - d0 !== 1) $display("FAIL parity_done cmd=%h got %0d want 1", cmds[i], doneCnt - d0); else npass++;
      repeat (5) @(negedge clockPs2);
    end
  endtask

  task automatic test_nack();
    logic [10:0] seen;
    logic [7:0] cmd;
    int inh, dinh, d0, e0;
    bit rel;
    cmd = 8'($urandom_range(0, 255));
    d0 = doneCnt; e0 = errCnt;
    do_send(cmd);
    device_frame(1'b0, 11, 1'b0, 1'b0, 8'h00, seen, inh, dinh, rel);
    wait_end(d0, e0);
    ntotal++; if (seen !== expected_frame(cmd)) $display("FAIL nack_frame got %b want %b", seen, expected_frame(cmd)); else npass++;
    ntotal++; if (errCnt - e0 !== 1) $display("FAIL nack_error got %0d want 1", errCnt - e0); else npass++;
    ntotal++; if (doneCnt - d0 !== 0) $display("FAIL nack_done got %0d want 0", doneCnt - d0); else npass++;
    ntotal++; if (hostIf.busy !== 1'b0) $display("FAIL nack_busy got %b want 0", hostIf.busy); else npass++;
    repeat (5) @(negedge clockPs2);
  endtask

  task automatic test_timeout();
    int d0, e0, relCyc, errCyc;
    logic clkOeAtErr, datOeAtErr;
    d0 = doneCnt; e0 = errCnt;
    relCyc = -1; errCyc = -1;
    clkOeAtErr = 1'bx; datOeAtErr = 1'bx;
    do_send(8'($urandom_range(0, 255)));
    for (int i = 0; i < 4 * INH && ps2ClkOe === 1'b1; i++) @(negedge clockPs2);
    if (ps2ClkOe === 1'b0) relCyc = cyc;
    for (int i = 0; i < TMO + 100 && errCnt == e0; i++) @(negedge clockPs2);
    if (errCnt != e0) begin
      errCyc = cyc;
      clkOeAtErr = ps2ClkOe;
      datOeAtErr = ps2DatOe;
    end
    ntotal++; if (errCyc - relCyc !== TMO || relCyc < 0 || errCyc < 0)
      $display("FAIL timeout_delay got %0d want %0d", errCyc - relCyc, TMO); else npass++;
    ntotal++; if ({clkOeAtErr, datOeAtErr} !== 2'b00) $display("FAIL timeout_oe got %b%b want 00", clkOeAtErr, datOeAtErr); else npass++;
    ntotal++; if (hostIf.busy !== 1'b0) $display("FAIL timeout_busy got %b want 0", hostIf.busy); else npass++;
    repeat (5) @(negedge clockPs2);
    ntotal++; if (doneCnt - d0 !== 0) $display("FAIL timeout_done got %0d want 0", doneCnt - d0); else npass++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] seen;
    int inh, dinh, e0;
    bit rel;
    e0 = errCnt;
    do_send(8'hA5);
    device_frame(1'b1, 4, 1'b0, 1'b0, 8'h00, seen, inh, dinh, rel);
    ntotal++; if (ps2DatOe !== 1'b1) $display("FAIL mid_datoe_bit3 got %b want 1", ps2DatOe); else npass++;
    reset = 1'b1;
    @(negedge clockPs2);
    ntotal++; if ({ps2ClkOe, ps2DatOe} !== 2'b00) $display("FAIL mid_reset_oe got %b%b want 00", ps2ClkOe, ps2DatOe); else npass++;
    ntotal++; if (hostIf.busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", hostIf.busy); else npass++;
    reset = 1'b0;
    repeat (10) @(negedge clockPs2);
    ntotal++; if (errCnt - e0 !== 0) $display("FAIL mid_reset_error got %0d want 0", errCnt - e0); else npass++;
    test_frame(8'hFF, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    hostIf.send = 1'b0;
    hostIf.command = 8'h00;
    @(negedge clockPs2);
    test_reset();
    test_frame(8'hED, 1'b0, 1'b0, "cmd_ed");
    for (int i = 0; i < 4; i++) test_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, "random");
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, "resend_ignored");
    test_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, "clk_glitch");
    ntotal++; if (bothCnt !== 0) $display("FAIL done_and_error_together got %0d want 0", bothCnt); else npass++;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
